// File: rtl/spi_periph_bridge.sv
// Turns completed SPI register transactions into single peripheral bus cycles.
// Read data comes back on reg_data_i, masked to the transaction width, with a timeout on ready.
module spi_periph_bridge #(
    parameter int ADDR_W      = 6,
    parameter int REG_W       = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              ena,
    input  logic [ADDR_W-1:0] reg_addr,
    input  logic              reg_rw,
    input  logic [1:0]        txn_width,
    input  logic [REG_W-1:0]  reg_data_o,
    input  logic              reg_data_o_dv,
    input  logic              reg_addr_v,
    output logic [REG_W-1:0]  reg_data_i,
    output logic [ADDR_W-1:0] per_addr,
    output logic [REG_W-1:0]  per_data_out,
    output logic [1:0]        per_data_write_n,
    output logic [1:0]        per_data_read_n,
    input  logic [REG_W-1:0]  per_data_in,
    input  logic              per_data_ready,
    output logic              busy,
    output logic              err
);

    // state  | meaning
    // IDLE   | waiting for a write strobe or a read-address rise
    // WRITE  | write strobe on the bus for exactly one enabled cycle
    // READ   | read strobe held until ready or timeout
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_READ  = 2'd2;

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

    logic [1:0]       state;
    logic             reg_addr_v_q;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             rd_rise;
    logic             wr_req;
    logic [REG_W-1:0] masked_data;

    assign rd_rise  = reg_addr_v & ~reg_addr_v_q;
    assign wr_req   = reg_data_o_dv & reg_rw & (txn_width != 2'b11);
    assign cnt_next = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    assign busy     = (state != ST_IDLE);

    // The latched read width lives in the active read strobe.
    always_comb begin
        masked_data = per_data_in;
        case (per_data_read_n)
            2'b00:   masked_data = {{(REG_W-8){1'b0}}, per_data_in[7:0]};
            2'b01:   masked_data = {{(REG_W-16){1'b0}}, per_data_in[15:0]};
            default: masked_data = per_data_in;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state            <= ST_IDLE;
            reg_addr_v_q     <= 1'b0;
            cnt              <= '0;
            per_addr         <= '0;
            per_data_out     <= '0;
            reg_data_i       <= '0;
            per_data_write_n <= 2'b11;
            per_data_read_n  <= 2'b11;
            err              <= 1'b0;
        end else if (ena) begin
            reg_addr_v_q <= reg_addr_v;
            case (state)
                ST_IDLE: begin
                    if (wr_req) begin
                        per_addr         <= reg_addr;
                        per_data_out     <= reg_data_o;
                        per_data_write_n <= txn_width;
                        state            <= ST_WRITE;
                    end else if (rd_rise && !reg_rw) begin
                        if (txn_width != 2'b11) begin
                            per_addr        <= reg_addr;
                            per_data_read_n <= txn_width;
                            cnt             <= '0;
                            state           <= ST_READ;
                        end else begin
                            reg_data_i <= '0;
                        end
                    end
                end
                ST_WRITE: begin
                    per_data_write_n <= 2'b11;
                    state            <= ST_IDLE;
                    if (reg_data_o_dv || rd_rise) err <= 1'b1;
                end
                ST_READ: begin
                    cnt <= cnt_next;
                    if (reg_data_o_dv || rd_rise) err <= 1'b1;
                    if (per_data_ready) begin
                        reg_data_i      <= masked_data;
                        per_data_read_n <= 2'b11;
                        state           <= ST_IDLE;
                    end else if (cnt_next == CNT_MAX) begin
                        reg_data_i      <= '1;
                        err             <= 1'b1;
                        per_data_read_n <= 2'b11;
                        state           <= ST_IDLE;
                    end
                end
                default: begin
                    per_data_write_n <= 2'b11;
                    per_data_read_n  <= 2'b11;
                    state            <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_periph_bridge.sv
// Self-checking bench for spi_periph_bridge with a transaction-level reference model.
module tb_spi_periph_bridge;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rstb;
    logic        ena;
    logic [5:0]  reg_addr;
    logic        reg_rw;
    logic [1:0]  txn_width;
    logic [31:0] reg_data_o;
    logic        reg_data_o_dv;
    logic        reg_addr_v;
    logic [31:0] reg_data_i;
    logic [5:0]  per_addr;
    logic [31:0] per_data_out;
    logic [1:0]  per_data_write_n;
    logic [1:0]  per_data_read_n;
    logic [31:0] per_data_in;
    logic        per_data_ready;
    logic        busy;
    logic        err;

    int cmp_cnt  = 0;
    int fail_cnt = 0;

    logic [5:0]  exp_addr;
    logic [31:0] exp_dout;
    logic [31:0] exp_rdata;
    logic        exp_err;

    spi_periph_bridge #(.ADDR_W(6), .REG_W(32), .TIMEOUT_CYC(T)) dut (
        .clk(clk), .rstb(rstb), .ena(ena),
        .reg_addr(reg_addr), .reg_rw(reg_rw), .txn_width(txn_width),
        .reg_data_o(reg_data_o), .reg_data_o_dv(reg_data_o_dv), .reg_addr_v(reg_addr_v),
        .reg_data_i(reg_data_i), .per_addr(per_addr), .per_data_out(per_data_out),
        .per_data_write_n(per_data_write_n), .per_data_read_n(per_data_read_n),
        .per_data_in(per_data_in), .per_data_ready(per_data_ready),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mask(input logic [1:0] w, input logic [31:0] d);
        case (w)
            2'b00:   return d & 32'h0000_00FF;
            2'b01:   return d & 32'h0000_FFFF;
            default: return d;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstb = 1'b0; ena = 1'b0; reg_addr = '0; reg_rw = 1'b0; txn_width = 2'b11;
        reg_data_o = '0; reg_data_o_dv = 1'b0; reg_addr_v = 1'b0;
        per_data_in = '0; per_data_ready = 1'b0;
        tick(); tick();
        exp_addr = '0; exp_dout = '0; exp_rdata = '0; exp_err = 1'b0;
        cmp_cnt++;
        if ({per_data_write_n, per_data_read_n, busy, err} !== 6'b111100) begin
            fail_cnt++;
            $display("FAIL reset_ctrl: wr=%b rd=%b busy=%b err=%b, want 11 11 0 0",
                     per_data_write_n, per_data_read_n, busy, err);
        end
        cmp_cnt++;
        if (per_addr !== 6'd0 || per_data_out !== 32'd0 || reg_data_i !== 32'd0) begin
            fail_cnt++;
            $display("FAIL reset_data: addr=%h dout=%h rdata=%h, want all 0",
                     per_addr, per_data_out, reg_data_i);
        end
        rstb = 1'b1; ena = 1'b1;
        tick();
    endtask

    task automatic do_write(input logic [5:0] a, input logic [1:0] w, input logic [31:0] d);
        logic [1:0] exp_wn;
        reg_addr = a; txn_width = w; reg_data_o = d; reg_rw = 1'b1; reg_data_o_dv = 1'b1;
        tick();
        reg_data_o_dv = 1'b0;
        if (w != 2'b11) begin
            exp_addr = a; exp_dout = d; exp_wn = w;
        end else begin
            exp_wn = 2'b11;
        end
        cmp_cnt++;
        if (per_data_write_n !== exp_wn || per_addr !== exp_addr || per_data_out !== exp_dout
            || busy !== (w != 2'b11)) begin
            fail_cnt++;
            $display("FAIL write_strobe: wn=%b addr=%h dout=%h busy=%b, want %b %h %h %b",
                     per_data_write_n, per_addr, per_data_out, busy, exp_wn, exp_addr, exp_dout, w != 2'b11);
        end
        tick();
        cmp_cnt++;
        if (per_data_write_n !== 2'b11 || busy !== 1'b0 || err !== exp_err) begin
            fail_cnt++;
            $display("FAIL write_end: wn=%b busy=%b err=%b, want 11 0 %b",
                     per_data_write_n, busy, err, exp_err);
        end
    endtask

    // d: cycles after the strobe appears before ready goes high (>= T means never in time)
    task automatic do_read(input logic [5:0] a, input logic [1:0] w, input int d,
                           input logic [31:0] data, input int hold, input int coll_k);
        int  strobe_cycles;
        int  exp_cycles;
        bit  done;
        bit  wr_seen;
        reg_addr = a; txn_width = w; reg_rw = 1'b0; reg_addr_v = 1'b1;
        per_data_in = data; per_data_ready = 1'b0;
        tick();
        if (w == 2'b11) begin
            exp_rdata = '0;
            cmp_cnt++;
            if (per_data_read_n !== 2'b11 || reg_data_i !== 32'd0 || busy !== 1'b0) begin
                fail_cnt++;
                $display("FAIL read_none: rn=%b rdata=%h busy=%b, want 11 0 0",
                         per_data_read_n, reg_data_i, busy);
            end
        end else begin
            exp_addr = a;
            cmp_cnt++;
            if (per_data_read_n !== w || per_addr !== a || busy !== 1'b1) begin
                fail_cnt++;
                $display("FAIL read_strobe: rn=%b addr=%h busy=%b, want %b %h 1",
                         per_data_read_n, per_addr, busy, w, a);
            end
            strobe_cycles = 1;
            done = 1'b0;
            wr_seen = 1'b0;
            for (int k = 0; k < T + 4; k++) begin
                per_data_ready = (k >= d);
                if (k == coll_k) begin
                    reg_rw = 1'b1; reg_data_o_dv = 1'b1; reg_data_o = $urandom;
                    exp_err = 1'b1;
                end
                tick();
                reg_rw = 1'b0; reg_data_o_dv = 1'b0;
                if (per_data_write_n !== 2'b11) wr_seen = 1'b1;
                if (per_data_read_n === 2'b11) begin
                    done = 1'b1;
                    break;
                end
                strobe_cycles++;
            end
            per_data_ready = 1'b0;
            exp_cycles = (d < T) ? d + 1 : T;
            if (d < T) begin
                exp_rdata = mask(w, data);
            end else begin
                exp_rdata = 32'hFFFF_FFFF;
                exp_err = 1'b1;
            end
            cmp_cnt++;
            if (!done || strobe_cycles != exp_cycles || wr_seen) begin
                fail_cnt++;
                $display("FAIL read_len: done=%0d cycles=%0d wr_seen=%0d, want 1 %0d 0",
                         done, strobe_cycles, wr_seen, exp_cycles);
            end
            cmp_cnt++;
            if (reg_data_i !== exp_rdata || busy !== 1'b0) begin
                fail_cnt++;
                $display("FAIL read_data: rdata=%h busy=%b, want %h 0", reg_data_i, busy, exp_rdata);
            end
        end
        cmp_cnt++;
        if (err !== exp_err) begin
            fail_cnt++;
            $display("FAIL read_err: err=%b, want %b", err, exp_err);
        end
        if (hold > 0) begin
            per_data_ready = 1'b1;
            wr_seen = 1'b0;
            for (int i = 0; i < hold; i++) begin
                tick();
                if (per_data_read_n !== 2'b11 || busy !== 1'b0 || reg_data_i !== exp_rdata) wr_seen = 1'b1;
            end
            per_data_ready = 1'b0;
            cmp_cnt++;
            if (wr_seen) begin
                fail_cnt++;
                $display("FAIL read_hold: second read seen, rn=%b rdata=%h, want 11 %h",
                         per_data_read_n, reg_data_i, exp_rdata);
            end
        end
        reg_addr_v = 1'b0;
        tick();
    endtask

    task automatic test_write_word();
        do_write(6'h05, 2'b10, 32'hA5A5_1234);
    endtask

    task automatic test_read_byte();
        do_read(6'h02, 2'b00, 3, 32'hDEAD_BEEF, 0, -1);
    endtask

    task automatic test_read_half_hold();
        do_read(6'h11, 2'b01, 0, 32'hDEAD_BEEF, 20, -1);
    endtask

    task automatic test_none_width();
        do_read(6'h07, 2'b11, 0, 32'h1234_5678, 0, -1);
        do_write(6'h09, 2'b11, 32'h5555_AAAA);
    endtask

    task automatic test_collision();
        do_read(6'h0C, 2'b10, 4, 32'hCAFE_F00D, 0, 1);
    endtask

    task automatic test_timeout();
        do_read(6'h03, 2'b10, 100, 32'h0BAD_0BAD, 0, -1);
        do_read(6'h04, 2'b00, 1, 32'h0000_0077, 0, -1);
    endtask

    task automatic test_ena();
        bit bad;
        reg_addr = 6'h21; txn_width = 2'b01; reg_rw = 1'b0; reg_addr_v = 1'b1;
        per_data_in = 32'h1357_9BDF; per_data_ready = 1'b0;
        tick();
        ena = 1'b0; per_data_ready = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < T + 2; i++) begin
            tick();
            if (per_data_read_n !== 2'b01 || reg_data_i !== exp_rdata || busy !== 1'b1) bad = 1'b1;
        end
        cmp_cnt++;
        if (bad) begin
            fail_cnt++;
            $display("FAIL ena_freeze: rn=%b rdata=%h busy=%b, want 01 %h 1",
                     per_data_read_n, reg_data_i, busy, exp_rdata);
        end
        ena = 1'b1;
        tick();
        exp_addr = 6'h21;
        exp_rdata = 32'h0000_9BDF;
        cmp_cnt++;
        if (per_data_read_n !== 2'b11 || reg_data_i !== exp_rdata || err !== exp_err) begin
            fail_cnt++;
            $display("FAIL ena_resume: rn=%b rdata=%h err=%b, want 11 %h %b",
                     per_data_read_n, reg_data_i, err, exp_rdata, exp_err);
        end
        per_data_ready = 1'b0; reg_addr_v = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_read();
        reg_addr = 6'h2A; txn_width = 2'b10; reg_rw = 1'b0; reg_addr_v = 1'b1;
        tick(); tick();
        rstb = 1'b0; ena = 1'b0; reg_addr_v = 1'b0;
        tick();
        exp_addr = '0; exp_dout = '0; exp_rdata = '0; exp_err = 1'b0;
        cmp_cnt++;
        if (per_data_read_n !== 2'b11 || per_data_write_n !== 2'b11 || busy !== 1'b0 || err !== 1'b0
            || per_addr !== 6'd0 || per_data_out !== 32'd0 || reg_data_i !== 32'd0) begin
            fail_cnt++;
            $display("FAIL reset_mid: rn=%b wn=%b busy=%b err=%b addr=%h dout=%h rdata=%h, want reset values",
                     per_data_read_n, per_data_write_n, busy, err, per_addr, per_data_out, reg_data_i);
        end
        rstb = 1'b1; ena = 1'b1;
        tick();
        do_read(6'h2B, 2'b10, 2, 32'h8765_4321, 0, -1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic [5:0]  a;
            logic [1:0]  w;
            logic [31:0] d;
            a = 6'($urandom);
            w = 2'($urandom_range(0, 3));
            d = $urandom;
            if ($urandom_range(0, 1) == 0)
                do_write(a, w, d);
            else
                do_read(a, w, int'($urandom_range(0, T + 2)), d, 0, -1);
        end
    endtask

    initial begin
        test_reset();
        test_write_word();
        test_read_byte();
        test_read_half_hold();
        test_none_width();
        test_collision();
        test_timeout();
        test_ena();
        test_reset_mid_read();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule
